// File: rtl/vga_grid_cursor_if.sv
// Pixel stream bundle between the sync generator/palette stage and the VGA DAC.
// The master drives the raw pixel stream and reads back the overlaid one.
interface vga_grid_cursor_if;
    localparam int unsigned BGR_W = 24;

    logic             iHS;
    logic             iVS;
    logic             iBLANK_n;
    logic [BGR_W-1:0] iBGR;
    logic             oHS;
    logic             oVS;
    logic             oBLANK_n;
    logic [BGR_W-1:0] oBGR;

    modport master (output iHS, iVS, iBLANK_n, iBGR, input  oHS, oVS, oBLANK_n, oBGR);
    modport slave  (input  iHS, iVS, iBLANK_n, iBGR, output oHS, oVS, oBLANK_n, oBGR);
endinterface

// File: rtl/vga_grid_cursor.sv
// Pixel overlay stage: draws a cell grid plus a PS/2-arrow-driven cursor cell.
// The drawn cursor position is latched only at the vsync falling edge, so a frame is never torn.
module vga_grid_cursor #(
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned GRID_X0   = 240,
    parameter int unsigned GRID_Y0   = 80,
    parameter int unsigned GRID_COLS = 10,
    parameter int unsigned GRID_ROWS = 20,
    parameter int unsigned START_COL = 5,
    parameter int unsigned START_ROW = 0,
    parameter int unsigned WRAP      = 0,
    parameter logic [23:0] LINE_BGR  = 24'h444444,
    parameter logic [23:0] CUR_BGR   = 24'hFF0000
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    vga_grid_cursor_if.slave   vga,
    input  logic [7:0]         ps2_out,
    input  logic               ps2_key_pressed,
    output logic [5:0]         oCUR_COL,
    output logic [5:0]         oCUR_ROW,
    output logic               oMOVE
);
    localparam int unsigned POS_W  = 10;
    localparam int unsigned CELL_W = 6;
    localparam int unsigned BGR_W  = 24;
    localparam int unsigned GRID_W = GRID_COLS << CELL_LOG2;
    localparam int unsigned GRID_H = GRID_ROWS << CELL_LOG2;
    localparam int unsigned CELL_M = (1 << CELL_LOG2) - 1;

    typedef enum logic [0:0] {ST_IDLE, ST_BREAK} key_state_e;

    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              hs_q, vs_q, blank_q;
    logic [BGR_W-1:0]  bgr_q, bgr_d;
    logic [1:0]        sync_q;
    logic              prev_q;
    key_state_e        state_q, state_d;
    logic [CELL_W-1:0] pcol_q, pcol_d, prow_q, prow_d;
    logic [CELL_W-1:0] dcol_q, drow_q;
    logic              move_q, move_d;

    logic              key_evt;
    logic [POS_W-1:0]  gx, gy;
    logic              in_grid, on_line, on_cur;

    assign key_evt = sync_q[1] & ~prev_q;

    // Pixel position: x counts active pixels, y counts blank falling edges since vsync.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!vga.iVS) begin
            x_d = '0;
            y_d = '0;
        end else if (blank_q && !vga.iBLANK_n) begin
            x_d = '0;
            y_d = y_q + POS_W'(1);
        end else if (vga.iBLANK_n) begin
            x_d = x_q + POS_W'(1);
        end
    end

    // Pixel classification against the latched (displayed) cursor cell.
    always_comb begin
        gx      = x_q - POS_W'(GRID_X0);
        gy      = y_q - POS_W'(GRID_Y0);
        in_grid = (x_q >= POS_W'(GRID_X0)) && (x_q < POS_W'(GRID_X0 + GRID_W)) &&
                  (y_q >= POS_W'(GRID_Y0)) && (y_q < POS_W'(GRID_Y0 + GRID_H));
        on_line = in_grid && (((gx & POS_W'(CELL_M)) == '0) || ((gy & POS_W'(CELL_M)) == '0));
        on_cur  = in_grid && !on_line &&
                  ((gx >> CELL_LOG2) == POS_W'(dcol_q)) && ((gy >> CELL_LOG2) == POS_W'(drow_q));
        bgr_d   = vga.iBGR;
        if (!vga.iBLANK_n) bgr_d = '0;
        else if (on_cur)   bgr_d = CUR_BGR;
        else if (on_line)  bgr_d = LINE_BGR;
    end

    // Key FSM: arrow make codes move the pending cell; the byte after F0 is swallowed.
    always_comb begin
        state_d = state_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        if (key_evt) begin
            case (state_q)
                ST_IDLE: begin
                    case (ps2_out)
                        8'hF0: state_d = ST_BREAK;
                        8'h75: begin
                            if (prow_q != '0)    prow_d = prow_q - CELL_W'(1);
                            else if (WRAP != 0)  prow_d = CELL_W'(GRID_ROWS - 1);
                        end
                        8'h72: begin
                            if (prow_q != CELL_W'(GRID_ROWS - 1)) prow_d = prow_q + CELL_W'(1);
                            else if (WRAP != 0)                   prow_d = '0;
                        end
                        8'h6B: begin
                            if (pcol_q != '0)    pcol_d = pcol_q - CELL_W'(1);
                            else if (WRAP != 0)  pcol_d = CELL_W'(GRID_COLS - 1);
                        end
                        8'h74: begin
                            if (pcol_q != CELL_W'(GRID_COLS - 1)) pcol_d = pcol_q + CELL_W'(1);
                            else if (WRAP != 0)                   pcol_d = '0;
                        end
                        default: ;
                    endcase
                end
                ST_BREAK: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        move_d = (pcol_d != pcol_q) || (prow_d != prow_q);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            bgr_q   <= '0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            state_q <= ST_IDLE;
            pcol_q  <= CELL_W'(START_COL);
            prow_q  <= CELL_W'(START_ROW);
            dcol_q  <= CELL_W'(START_COL);
            drow_q  <= CELL_W'(START_ROW);
            move_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= vga.iHS;
            vs_q    <= vga.iVS;
            blank_q <= vga.iBLANK_n;
            bgr_q   <= bgr_d;
            sync_q  <= {sync_q[0], ps2_key_pressed};
            prev_q  <= sync_q[1];
            state_q <= state_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            move_q  <= move_d;
            // vs_q still high while iVS is low marks the vsync falling edge
            if (vs_q && !vga.iVS) begin
                dcol_q <= pcol_q;
                drow_q <= prow_q;
            end
        end
    end

    assign vga.oHS      = hs_q;
    assign vga.oVS      = vs_q;
    assign vga.oBLANK_n = blank_q;
    assign vga.oBGR     = bgr_q;
    assign oCUR_COL     = pcol_q;
    assign oCUR_ROW     = prow_q;
    assign oMOVE        = move_q;
endmodule

// File: tb/tb_vga_grid_cursor.sv
// Directed bench for vga_grid_cursor: clamp and wrap instances share one stimulus stream.
module tb_vga_grid_cursor;
    localparam logic [23:0] LINE = 24'h444444;
    localparam logic [23:0] CUR  = 24'hFF0000;
    localparam logic [23:0] BG   = 24'h00AA55;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ps2_out;
    logic       key;
    logic [5:0] col, row, col_w, row_w;
    logic       move, move_w;
    int         checks = 0;
    int         errors = 0;
    int         mv_cnt = 0;
    int         mv_cnt_w = 0;
    int         mv0, mvw0;

    vga_grid_cursor_if vif ();
    vga_grid_cursor_if vif_w ();

    assign vif_w.iHS      = vif.iHS;
    assign vif_w.iVS      = vif.iVS;
    assign vif_w.iBLANK_n = vif.iBLANK_n;
    assign vif_w.iBGR     = vif.iBGR;

    always #5 clk = ~clk;

    vga_grid_cursor #(.WRAP(0)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .vga(vif.slave), .ps2_out(ps2_out),
        .ps2_key_pressed(key), .oCUR_COL(col), .oCUR_ROW(row), .oMOVE(move));

    vga_grid_cursor #(.WRAP(1)) dut_w (
        .iVGA_CLK(clk), .iRST_n(rst_n), .vga(vif_w.slave), .ps2_out(ps2_out),
        .ps2_key_pressed(key), .oCUR_COL(col_w), .oCUR_ROW(row_w), .oMOVE(move_w));

    always @(posedge clk) begin
        if (move)   mv_cnt   <= mv_cnt + 1;
        if (move_w) mv_cnt_w <= mv_cnt_w + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] b);
        @(negedge clk);
        ps2_out = b;
        key     = 1'b1;
        repeat (4) @(negedge clk);
        key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vsync();
        @(negedge clk);
        vif.iVS      = 1'b0;
        vif.iBLANK_n = 1'b0;
        repeat (2) @(negedge clk);
        vif.iVS = 1'b1;
    endtask

    task automatic short_lines(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vif.iBLANK_n = 1'b1;
            @(negedge clk) vif.iBLANK_n = 1'b0;
        end
    endtask

    // One active line; pixel columns xa/xb are checked one cycle after they are driven.
    task automatic long_line(input int len, input int xa, input logic [23:0] ea, input string ta,
                             input int xb, input logic [23:0] eb, input string tb_tag);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            vif.iBLANK_n = 1'b1;
            vif.iBGR     = BG;
            @(posedge clk);
            #1;
            if (i == xa) check(ta, 32'(vif.oBGR), 32'(ea));
            if (i == xb) check(tb_tag, 32'(vif.oBGR), 32'(eb));
        end
        @(negedge clk) vif.iBLANK_n = 1'b0;
        @(posedge clk);
        #1;
        check("blank_bgr", 32'(vif.oBGR), 32'd0);
        check("blank_out", 32'(vif.oBLANK_n), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        vif.iHS      = 1'b1;
        vif.iVS      = 1'b1;
        vif.iBLANK_n = 1'b0;
        vif.iBGR     = BG;
        ps2_out      = 8'h00;
        key          = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset asserted mid-line
        @(negedge clk);
        vif.iHS      = 1'b0;
        vif.iBLANK_n = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_hs", 32'(vif.oHS), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_hs", 32'(vif.oHS), 32'd1);
        check("rst_vs", 32'(vif.oVS), 32'd1);
        check("rst_blank", 32'(vif.oBLANK_n), 32'd0);
        check("rst_bgr", 32'(vif.oBGR), 32'd0);
        check("rst_col", 32'(col), 32'd5);
        check("rst_row", 32'(row), 32'd0);
        check("rst_move", 32'(move), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        vif.iHS      = 1'b1;
        vif.iBLANK_n = 1'b0;

        // up from row 0: clamp ignores it, wrap goes to the last row
        mv0  = mv_cnt;
        mvw0 = mv_cnt_w;
        send_key(8'h75);
        check("clamp_row", 32'(row), 32'd0);
        check("clamp_moves", 32'(mv_cnt - mv0), 32'd0);
        check("wrap_row", 32'(row_w), 32'd19);
        check("wrap_moves", 32'(mv_cnt_w - mvw0), 32'd1);

        // frame A: keys arrive mid-frame, display keeps the old cell
        vsync();
        short_lines(81);
        mv0 = mv_cnt;
        @(negedge clk);
        ps2_out = 8'h74;
        key     = 1'b1;
        @(posedge clk) #1 check("key_t1", 32'(move), 32'd0);
        @(posedge clk) #1 check("key_t2", 32'(move), 32'd0);
        @(posedge clk) #1 check("key_t3", 32'(move), 32'd1);
        check("key_t3_col", 32'(col), 32'd6);
        @(posedge clk) #1 check("key_t4", 32'(move), 32'd0);
        @(negedge clk) key = 1'b0;
        repeat (4) @(negedge clk);
        send_key(8'h74);
        check("right2_col", 32'(col), 32'd7);
        check("right2_moves", 32'(mv_cnt - mv0), 32'd2);
        long_line(360, 321, CUR, "old_cell_cur", 353, BG, "new_cell_bg");

        // frame B: new cell visible after the vsync fall
        vsync();
        short_lines(80);
        long_line(360, 352, LINE, "cur_topleft_line", 353, LINE, "top_edge_line");
        long_line(360, 353, CUR, "new_cell_cur", 321, BG, "old_cell_bg");
        short_lines(18);
        long_line(250, 240, LINE, "grid_left_line", 239, BG, "left_of_grid");

        // one-cycle lag on sync
        @(negedge clk) vif.iHS = 1'b0;
        #1 check("hs_lag_before", 32'(vif.oHS), 32'd1);
        @(posedge clk) #1 check("hs_lag_after", 32'(vif.oHS), 32'd0);
        @(negedge clk) vif.iHS = 1'b1;

        // break filtering from row 3
        send_key(8'h72);
        send_key(8'h72);
        send_key(8'h72);
        check("down3_row", 32'(row), 32'd3);
        mv0 = mv_cnt;
        send_key(8'hE0);
        send_key(8'h75);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        check("break_row", 32'(row), 32'd2);
        check("break_moves", 32'(mv_cnt - mv0), 32'd1);

        // reset in the middle of a break sequence
        send_key(8'hF0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("rst2_col", 32'(col), 32'd5);
        check("rst2_row", 32'(row), 32'd0);
        mv0 = mv_cnt;
        send_key(8'h72);
        check("post_rst_row", 32'(row), 32'd1);
        check("post_rst_moves", 32'(mv_cnt - mv0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
